// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (port 0) and a DMA/debug master (port 1).
// Optional grant/stall statistics outputs are enabled by defining DMEM_ARB_STATS_EN.

// Registered read return for one port: one-cycle rvalid pulse, rdata held between reads.
module dmem_arb_rport #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt,
  input  logic          we,
  input  logic [DW-1:0] mem_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (gnt & ~we) rdata <= mem_rdata;
    end
  end
endmodule

module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   gnt_cnt0,
  output logic [31:0]   gnt_cnt1,
  output logic [7:0]    max_wait0
`endif
);
  typedef enum logic [1:0] {NONE = 2'd0, P0 = 2'd1, P1 = 2'd2} owner_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  owner_t     owner, owner_nxt;
  logic [3:0] burst_cnt, burst_nxt, burst_inc;
  logic [1:0] req, we, gnt, rvalid;
  logic [1:0][DW-1:0] rdata;

  assign req = {m1_req, m0_req};
  assign we  = {m1_we, m0_we};

  // Owner keeps the port until the other side has waited out a full burst.
  always_comb begin
    gnt = 2'b00;
    case (owner)
      P0: begin
        if (req[0] && (!req[1] || burst_cnt < BURST_LIM)) gnt = 2'b01;
        else if (req[1])                                  gnt = 2'b10;
      end
      P1: begin
        if (req[1] && (!req[0] || burst_cnt < BURST_LIM)) gnt = 2'b10;
        else if (req[0])                                  gnt = 2'b01;
      end
      default: begin
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
      end
    endcase
    if (!rst) gnt = 2'b00;
  end

  assign burst_inc = (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;

  always_comb begin
    owner_nxt = NONE;
    burst_nxt = 4'd0;
    if (gnt[0]) begin
      owner_nxt = P0;
      burst_nxt = (owner == P0) ? burst_inc : 4'd1;
    end else if (gnt[1]) begin
      owner_nxt = P1;
      burst_nxt = (owner == P1) ? burst_inc : 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner     <= NONE;
      burst_cnt <= 4'd0;
    end else begin
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_stall  = m0_req & ~gnt[0];
  assign mem_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign mem_wdata = gnt[1] ? m1_wdata : m0_wdata;
  assign mem_we    = |(gnt & we);

  for (genvar p = 0; p < 2; p++) begin : g_rport
    dmem_arb_rport #(.DW(DW)) u_rport (
      .clk       (clk),
      .rst       (rst),
      .gnt       (gnt[p]),
      .we        (we[p]),
      .mem_rdata (mem_rdata),
      .rvalid    (rvalid[p]),
      .rdata     (rdata[p])
    );
  end

  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];

`ifdef DMEM_ARB_STATS_EN
  logic [7:0] wait_run, wait_nxt;

  // Length of the current stall run including this cycle.
  assign wait_nxt = m0_stall ? ((wait_run == 8'hFF) ? 8'hFF : wait_run + 8'd1) : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
      wait_run  <= '0;
      max_wait0 <= '0;
    end else begin
      gnt_cnt0  <= gnt_cnt0 + 32'(gnt[0]);
      gnt_cnt1  <= gnt_cnt1 + 32'(gnt[1]);
      wait_run  <= wait_nxt;
      if (wait_nxt > max_wait0) max_wait0 <= wait_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + randomized bench for dmem_arbiter against a cycle-level reference model of the arbitration rules.
// Define DMEM_ARB_STATS_EN to also check the statistics outputs.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MAX_BURST = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, mem_rdata = '0;
  logic m0_gnt, m0_rvalid, m0_stall, m1_gnt, m1_rvalid, mem_we;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gnt_cnt0, gnt_cnt1;
  logic [7:0]  max_wait0;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .max_wait0(max_wait0)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference state: last granted port (-1 none) and how many grants in a row it has had.
  int last = -1, run = 0, last_g = -1;
  int gq[$];
  logic erv0 = 0, erv1 = 0;
  logic [DW-1:0] erd0 = '0, erd1 = '0;
  logic [31:0] ec0 = '0, ec1 = '0;
  int ewait = 0, emax = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int lst, input int rn, input logic r0, input logic r1, input logic rs);
    logic own, oth;
    if (!rs) return -1;
    if (lst >= 0) begin
      own = (lst == 0) ? r0 : r1;
      oth = (lst == 0) ? r1 : r0;
      if (own && (!oth || rn < MAX_BURST)) return lst;
      if (oth) return 1 - lst;
      return -1;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    last = -1; run = 0; erv0 = 0; erv1 = 0; erd0 = '0; erd1 = '0;
    ec0 = '0; ec1 = '0; ewait = 0; emax = 0;
  endtask

  // Inputs are applied at negedge; combinational outputs checked just after, registered ones just after posedge.
  task automatic cycle();
    int g;
    logic [DW-1:0] md;
    logic w0, w1, rs, stall;
    #1;
    g = pick(last, run, m0_req, m1_req, rst);
    chk("m0_gnt", m0_gnt, g == 0);
    chk("m1_gnt", m1_gnt, g == 1);
    chk("mem_we", mem_we, (g == 0 && m0_we) || (g == 1 && m1_we));
    chk("mem_addr", mem_addr, (g == 1) ? m1_addr : m0_addr);
    chk("mem_wdata", mem_wdata, (g == 1) ? m1_wdata : m0_wdata);
    chk("m0_stall", m0_stall, m0_req && g != 0);
    md = mem_rdata; w0 = m0_we; w1 = m1_we; rs = rst; stall = m0_req && g != 0;
    gq.push_back(g);
    last_g = g;
    @(posedge clk);
    if (!rs) model_reset();
    else begin
      if (g < 0) begin last = -1; run = 0; end
      else if (g == last) run = (run < 15) ? run + 1 : 15;
      else begin last = g; run = 1; end
      erv0 = (g == 0 && !w0); if (erv0) erd0 = md;
      erv1 = (g == 1 && !w1); if (erv1) erd1 = md;
      if (g == 0) ec0 = ec0 + 1;
      if (g == 1) ec1 = ec1 + 1;
      ewait = stall ? ((ewait < 255) ? ewait + 1 : 255) : 0;
      if (ewait > emax) emax = ewait;
    end
    #1;
    chk("m0_rvalid", m0_rvalid, erv0);
    chk("m0_rdata", m0_rdata, erd0);
    chk("m1_rvalid", m1_rvalid, erv1);
    chk("m1_rdata", m1_rdata, erd1);
`ifdef DMEM_ARB_STATS_EN
    chk("gnt_cnt0", gnt_cnt0, ec0);
    chk("gnt_cnt1", gnt_cnt1, ec1);
    chk("max_wait0", max_wait0, emax);
`endif
    @(negedge clk);
  endtask

  initial begin
    int bp[12];
    bp = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    @(negedge clk);

    // Reset held with both ports requesting writes
    rst = 0; m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    m0_addr = 32'h4; m1_addr = 32'h8; m0_wdata = 32'h11; m1_wdata = 32'h22;
    repeat (3) cycle();
    m0_req = 0; m1_req = 0; rst = 1;
    cycle();

    // Uncontended read
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    cycle();
    chk("plan_rdata0", m0_rdata, 32'hDEADBEEF);
    m0_req = 0; mem_rdata = 32'h0;
    cycle();

    // Contention from idle: P0 first, then bursts of MAX_BURST
    gq.delete();
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    m1_req = 1; m1_we = 0; m1_addr = 32'h80;
    for (int i = 0; i < 12; i++) begin
      mem_rdata = $urandom;
      cycle();
    end
    for (int i = 0; i < 12; i++) chk("burst_seq", gq[i], bp[i]);
    m0_req = 0; m1_req = 0;
    cycle();

    // Write routing on port 1
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    cycle();
    m1_req = 0;
    cycle();

    // Port 1 read to load nonzero rdata, then a read cut off by reset
    m1_req = 1; m1_we = 0; m1_addr = 32'h24; mem_rdata = 32'hA5A50001;
    cycle();
    m1_addr = 32'h30; mem_rdata = 32'h0BADF00D;
    #1;
    chk("rmr_gnt", m1_gnt, 1'b1);
    rst = 0;
    #1;
    chk("rmr_gnt_forced", m1_gnt, 1'b0);
    @(posedge clk); #1;
    chk("rmr_rvalid", m1_rvalid, 1'b0);
    chk("rmr_rdata", m1_rdata, 32'h0);
`ifdef DMEM_ARB_STATS_EN
    chk("rmr_cnt0", gnt_cnt0, 32'h0);
    chk("rmr_cnt1", gnt_cnt1, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1; m1_req = 0; last_g = -1;
    cycle();

    // Random traffic obeying the hold-until-granted rule, with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (!m0_req || last_g == 0) begin
        m0_req = 1'($urandom_range(0, 1)); m0_we = 1'($urandom_range(0, 1));
        m0_addr = $urandom; m0_wdata = $urandom;
      end
      if (!m1_req || last_g == 1) begin
        m1_req = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
        m1_addr = $urandom; m1_wdata = $urandom;
      end
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 39) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
